// File: rtl/echo_processor_if.sv
// Sample/control bundle between the ADC capture side and the echo processor.
// The capture side (master) drives samples and configuration; the processor
// (slave) returns the DAC sample and status flags.
interface echo_processor_if #(
  parameter int WIDTH  = 10,
  parameter int ADDR_W = 13
);
  logic              data_valid;
  logic [WIDTH-1:0]  data_in;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] delay;
  logic [WIDTH-1:0]  data_out;
  logic              sample_strobe;
  logic              primed;
  logic              overrun;

  modport master (
    output data_valid, data_in, mode, delay,
    input  data_out, sample_strobe, primed, overrun
  );

  modport slave (
    input  data_valid, data_in, mode, delay,
    output data_out, sample_strobe, primed, overrun
  );
endinterface

// File: rtl/echo_processor.sv
// Audio echo processor with a programmable circular delay line.
// One sample per rising edge of the (asynchronous) data_valid strobe:
// offset-binary -> signed, bypass / feed-forward / feedback / mute,
// saturate, re-offset for the DAC. Three-state pipeline IDLE -> READ -> CALC.
module echo_processor #(
  parameter int               WIDTH      = 10,
  parameter int               ADDR_W     = 13,
  parameter logic [WIDTH-1:0] ADC_OFFSET = 10'h181,
  parameter logic [WIDTH-1:0] DAC_OFFSET = 10'h200,
  parameter int               GAIN_SHIFT = 1
) (
  input  logic           sysclk,
  input  logic           rst_n,
  echo_processor_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CALC} state_t;

  localparam logic [1:0]        M_BYP  = 2'b00;
  localparam logic [1:0]        M_FF   = 2'b01;
  localparam logic [1:0]        M_FB   = 2'b10;
  localparam logic [ADDR_W-1:0] A_ONE  = 1;
  localparam logic [ADDR_W-1:0] A_MAX  = '1;
  localparam logic [WIDTH-1:0]  S_MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  S_MINV = {1'b1, {(WIDTH-1){1'b0}}};

  // synchroniser + edge register
  logic r_s1, r_s2, r_s3;
  logic w_pulse;

  // pipeline state
  state_t                   r_state;
  logic [WIDTH-1:0]         r_x;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic [ADDR_W-1:0]        r_wr_ptr;
  logic signed [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]         r_data_out;
  logic                     r_strobe;
  logic                     r_overrun;

  // fill tracking / config change detection
  logic [ADDR_W-1:0]        r_fill;
  logic [1:0]               r_mode_q;
  logic [ADDR_W-1:0]        r_delay_q;
  logic                     w_cfg_chg;
  logic                     w_primed;

  // datapath
  logic [WIDTH-1:0]         r_mem [2**ADDR_W];
  logic [WIDTH-1:0]         w_e;
  logic [WIDTH:0]           w_y;
  logic [WIDTH-1:0]         w_sat;
  logic [WIDTH-1:0]         w_out;
  logic [WIDTH-1:0]         w_wr_data;
  logic                     w_wr_en;

  assign w_pulse   = r_s2 & ~r_s3;
  assign w_wr_en   = (r_state == S_CALC);
  assign w_cfg_chg = (bus.mode != r_mode_q) || (bus.delay != r_delay_q);
  assign w_primed  = (r_fill >= bus.delay);

  assign bus.data_out      = r_data_out;
  assign bus.sample_strobe = r_strobe;
  assign bus.primed        = w_primed;
  assign bus.overrun       = r_overrun;

  // bring data_valid into sysclk and keep one extra stage for rise detection
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.data_valid;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // registered copies of mode/delay, used only to spot a reconfiguration
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q  <= '0;
      r_delay_q <= '0;
    end else begin
      r_mode_q  <= bus.mode;
      r_delay_q <= bus.delay;
    end
  end

  // count valid samples in the line; a reconfiguration restarts the count,
  // and a write landing on that same cycle is the first of the new fill
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else if (w_cfg_chg) begin
      r_fill <= w_wr_en ? A_ONE : '0;
    end else if (w_wr_en && (r_fill != A_MAX)) begin
      r_fill <= r_fill + A_ONE;
    end
  end

  // delay-line RAM: unreset storage, registered read in READ, write in CALC
  always_ff @(posedge sysclk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
    if (r_state == S_READ) r_q <= $signed(r_mem[r_rd_addr]);
  end

  // echo term, difference at WIDTH+1 bits, clamp, and per-mode selection
  always_comb begin
    w_e = '0;
    if (w_primed && (bus.delay != '0)) w_e = r_q >>> GAIN_SHIFT;
    w_y = {r_x[WIDTH-1], r_x} - {w_e[WIDTH-1], w_e};
    // top two bits disagree only when the difference left the WIDTH range
    if (w_y[WIDTH] != w_y[WIDTH-1]) w_sat = w_y[WIDTH] ? S_MINV : S_MAXV;
    else                            w_sat = w_y[WIDTH-1:0];
    case (bus.mode)
      M_BYP:   begin w_out = r_x;   w_wr_data = r_x;   end
      M_FF:    begin w_out = w_sat; w_wr_data = r_x;   end
      M_FB:    begin w_out = w_sat; w_wr_data = w_sat; end
      default: begin w_out = '0;    w_wr_data = '0;    end
    endcase
  end

  // sample pipeline FSM with registered DAC output, strobe and overrun flag
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_rd_addr  <= '0;
      r_wr_ptr   <= '0;
      r_data_out <= DAC_OFFSET;
      r_strobe   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      // a new edge while a sample is in flight is lost; remember that
      if (w_pulse && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_pulse) begin
            r_x       <= bus.data_in - ADC_OFFSET;
            r_rd_addr <= r_wr_ptr - bus.delay;
            r_state   <= S_READ;
          end
        end
        S_READ: r_state <= S_CALC;
        S_CALC: begin
          r_data_out <= w_out + DAC_OFFSET;
          r_strobe   <= 1'b1;
          r_wr_ptr   <= r_wr_ptr + A_ONE;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/echo_processor.md
# echo_processor

Parametrised audio echo processor with a built-in circular delay line. It replaces the fixed allpass/FIFO-echo processor between ADC capture and DAC output. On each rising edge of `data_valid` it converts one offset-binary sample to two's complement and applies one of four modes: bypass, feed-forward echo, feedback echo or mute. It then saturates the result and re-offsets it for the DAC. Delay length is run-time programmable; echo gain is a power-of-two attenuation fixed by parameter.

## Interface
- `WIDTH`, 10: sample width (ADC in, DAC out, stored samples).
- `ADDR_W`, 13: delay-line address width; depth = 2^ADDR_W samples.
- `ADC_OFFSET`, 10'h181: subtracted from `data_in` to form signed x.
- `DAC_OFFSET`, 10'h200: added to the saturated result to form `data_out`.
- `GAIN_SHIFT`, 1: echo term = arithmetic right shift of delayed sample by `GAIN_SHIFT`.

- `sysclk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_valid`  in  1  sample strobe from ADC; asynchronous; rising edge = new sample.
- `data_in`  in  WIDTH  offset-binary ADC sample; stable while `data_valid` is high.
- `mode`  in  2  00 bypass, 01 feed-forward, 10 feedback, 11 mute.
- `delay`  in  ADDR_W  echo delay in samples; 0 = echo term forced to 0.
- `data_out`  out  WIDTH  offset-binary DAC sample.
- `sample_strobe`  out  1  one-cycle pulse in the cycle `data_out` updates.
- `primed`  out  1  delay line holds at least `delay` valid samples.
- `overrun`  out  1  sticky; a sample edge arrived while the pipeline was busy.

## Operation
- `data_valid` passes through a 2-flop synchroniser plus an edge register; pulse = s2 & ~s3.
- FSM states:
  - IDLE: on pulse, register x = `data_in` − ADC_OFFSET (mod 2^WIDTH, signed) and rd_addr = wr_ptr − `delay` (mod depth); go to READ.
  - READ: synchronous RAM read; register q; go to CALC.
  - CALC: compute y, update outputs, write RAM; go to IDLE.
- Echo term: e = (q >>> GAIN_SHIFT) if `primed` and `delay` ≠ 0, else 0.
- y = x − e, computed at WIDTH+1 bits, then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Per mode:
  - bypass: output x; write x.
  - feed-forward: output sat(y); write x.
  - feedback: output sat(y); write sat(y).
  - mute: output 0; write 0.
- `data_out` = output + DAC_OFFSET (mod 2^WIDTH). wr_ptr increments by 1 and wraps at depth.
- Fill counter: increments per written sample, saturates at depth−1. `primed` = (fill ≥ `delay`).
- Any change of `delay` or `mode` (compared against registered copies each cycle) clears the fill counter, so the delay line must re-prime. wr_ptr is not reset.
- A pulse in READ or CALC is dropped and sets `overrun`. `overrun` clears only on reset.
- RAM contents are not reset; the fill counter guarantees stale data is never used.

## Timing
- Reset values: `data_out` = DAC_OFFSET, `sample_strobe` = 0, `primed` = 0 when `delay` ≠ 0, `overrun` = 0. FSM = IDLE, wr_ptr = 0, fill = 0, synchroniser = 0.
- Let edge k be the first sysclk edge sampling `data_valid` high:
  - k+2: x latched; IDLE→READ.
  - k+3: q valid; READ→CALC.
  - k+4: `data_out` updated, `sample_strobe` = 1 for exactly one cycle, RAM written, wr_ptr incremented.
- Minimum `data_valid` period for lossless operation: 3 sysclk cycles.
- Reset asserted mid-pipeline: all state returns to reset values immediately; the in-flight sample produces no strobe.
- If a delay change coincides with the CALC write, that write counts as the first sample of the new fill.
- `delay` ≥ depth is impossible by width; `delay` = depth−1 is supported.

## Test plan
All scenarios use WIDTH=10, ADDR_W=4, GAIN_SHIFT=1, offsets 0x181/0x200.
- Reset: hold `rst_n`=0, toggle inputs → `data_out`=0x200, `sample_strobe`=0, `overrun`=0; after release, first strobe at k+4 only.
- Bypass: `data_in`=0x191 → `data_out`=0x210 on edge k+4, one-cycle strobe.
- Feed-forward, `delay`=2: x sequence 256, 0, 0, 0 (`data_in` 0x281, 0x181…) → `data_out` 0x300, 0x200, 0x180, 0x200.
- Feedback, `delay`=2: impulse 256 then zeros → 0x300, 0x200, 0x180, 0x200, 0x240, 0x200, 0x1E0.
- Saturation, feed-forward, `delay`=1: x = −512 (0x381) then +511 (0x380) → second output clamps to 0x3FF.
- Overrun/re-prime: two `data_valid` edges 2 cycles apart → one strobe, `overrun`=1. Then change `delay` 2→3 → `primed`=0 until 3 further samples, echo term 0 meanwhile.
